line_cmd_arbiter: RTL
=====================

Name: line_cmd_arbiter

Overview:
Shares the single Bresenham line-rasterizer engine among NUM_REQ line-command requesters, such as the triangle-edge and rectangle units. It grants requesters round-robin, captures the grant's endpoints, and rejects commands that fall outside the 64x64 canvas. Accepted commands drive one engine start pulse; the block then waits for engine done, with a timeout, and returns a per-requester completion or error pulse.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
COORD_W, 8, coordinate width
CANVAS_DIM, 64, valid coordinates are 0..CANVAS_DIM-1
TIMEOUT, 8192, maximum cycles spent in WAIT before the command is declared failed

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid, held until req_ready
req_x0, req_y0, req_x1, req_y1  in  [NUM_REQ-1:0][COORD_W-1:0]  per-requester endpoints
req_ready  out  NUM_REQ  one-hot capture handshake, combinational
done_ack  out  NUM_REQ  one-cycle pulse: line drawn
err_ack  out  NUM_REQ  one-cycle pulse: command failed
err_code  out  2  0 none, 1 out of bounds, 2 timeout; holds last value
eng_start  out  1  one-cycle start pulse to the engine
eng_x0, eng_y0, eng_x1, eng_y1  out  COORD_W  latched endpoints to the engine
eng_done  in  1  engine completion
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE; all registered outputs 0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-command abandons the command: no ack is issued, and eng_start is 0 the next cycle.
- States: IDLE -> CHECK -> ISSUE -> WAIT -> REPORT -> IDLE. CHECK can also go directly to REPORT.
- IDLE:
  - If any req_valid is set, g = first set bit searching from last_grant+1 with wrap.
  - req_ready[g]=1 in that same cycle. At the edge, latch the endpoints into eng_*, set grant_id=g, go to CHECK.
  - req_ready is 0 in all other states.
- CHECK (1 cycle):
  - If any endpoint >= CANVAS_DIM (unsigned compare), set err_code=1 and go to REPORT. No eng_start is issued.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): eng_start=1; timeout counter cleared; go to WAIT.
- WAIT:
  - The counter increments each cycle.
  - eng_done=1 -> REPORT with success.
  - Otherwise, counter==TIMEOUT-1 -> err_code=2 and go to REPORT.
  - eng_done and timeout in the same cycle: done wins.
- REPORT (1 cycle):
  - done_ack[grant_id] or err_ack[grant_id] = 1; err_code updated only on error.
  - last_grant=grant_id; go to IDLE.
- Latency:
  - Handshake at cycle T: eng_start at T+2; bounds error ack at T+2.
  - eng_done at cycle D: done_ack at D+1.
  - Earliest next handshake at D+2.
  - Timeout: err_ack at (start cycle)+1+TIMEOUT.
- eng_done outside WAIT is ignored.
- eng_* coordinates are stable from capture until the next capture.
- Degenerate lines (x0==x1 and y0==y1) are issued normally.
- A requester dropping req_valid before grant is legal; it is simply skipped.
- At most one done_ack/err_ack bit is set in any cycle, and never both.

Decomposition:
- Package gpu_line_pkg holds:
  - the state enum (IDLE, CHECK, ISSUE, WAIT, REPORT)
  - the err_code enum (ERR_NONE, ERR_BOUNDS, ERR_TIMEOUT)
  - COORD_W and CANVAS_DIM defaults
  - a line_cmd_t struct {x0,y0,x1,y1}
- Sub-module rr_arbiter: purely combinational. It takes req and last_grant and produces a one-hot grant and its index. Parameterised by NUM_REQ, and reusable by other shared GPU resources.

Test Plan:
1. Single request: req0 sends (12,12)->(45,40); engine model raises eng_done 10 cycles after start -> eng_start at T+2 with eng_* = 12,12,45,40; done_ack[0] one cycle after eng_done; busy falls the cycle after that.
2. Bounds: req1 sends (12,12)->(45,69) -> no eng_start; err_ack[1] with err_code=1 at T+2; engine is never started.
3. Round-robin: NUM_REQ=4, req0 and req2 held valid continuously with valid lines -> grant order 0,2,0,2; req1/req3 never acked.
4. Timeout: TIMEOUT=16, engine never asserts done -> err_ack with err_code=2 exactly 17 cycles after eng_start. Done and timeout asserted in the same cycle -> done_ack instead.
5. Reset mid-WAIT: rst for 1 cycle -> all outputs 0 next cycle and no ack. Afterwards req0 and req3 both valid -> req0 granted first.
6. Back-to-back: req2 keeps valid after its done_ack with a new command -> new handshake at D+2 with the new endpoints on eng_*.

Source files
------------

// File: rtl/gpu_line_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpu_line_pkg
// Brief    : Shared types and defaults for the line-command arbitration path.
// Revision : 1.0
// ============================================================================
package gpu_line_pkg;

    localparam int DEF_COORD_W    = 8;
    localparam int DEF_CANVAS_DIM = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BOUNDS  = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_code_t;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] x0;
        logic [DEF_COORD_W-1:0] y0;
        logic [DEF_COORD_W-1:0] x1;
        logic [DEF_COORD_W-1:0] y1;
    } line_cmd_t;

endpackage
`default_nettype wire

// File: rtl/line_cmd_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request after last_grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       any_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int               idx;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the ring starting one past the previous winner, wrapping at NUM_REQ.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_i) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = IDX_W'(idx);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/line_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : line_cmd_arbiter
// Brief    : Round-robin sharing of the line rasterizer with bounds/timeout.
// Revision : 1.0
// ============================================================================
module line_cmd_arbiter
    import gpu_line_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int COORD_W    = DEF_COORD_W,
    parameter int CANVAS_DIM = DEF_CANVAS_DIM,
    parameter int TIMEOUT    = 8192
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][COORD_W-1:0]  req_x0,
    input  logic [NUM_REQ-1:0][COORD_W-1:0]  req_y0,
    input  logic [NUM_REQ-1:0][COORD_W-1:0]  req_x1,
    input  logic [NUM_REQ-1:0][COORD_W-1:0]  req_y1,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REQ-1:0]               done_ack,
    output logic [NUM_REQ-1:0]               err_ack,
    output logic [1:0]                       err_code,
    output logic                             eng_start,
    output logic [COORD_W-1:0]               eng_x0,
    output logic [COORD_W-1:0]               eng_y0,
    output logic [COORD_W-1:0]               eng_x1,
    output logic [COORD_W-1:0]               eng_y1,
    input  logic                             eng_done,
    output logic                             busy,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    state_t             state_q, state_d;
    err_code_t          err_q, err_d;
    logic               fail_q, fail_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               oob;
    logic [NUM_REQ-1:0] ack_vec;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .any_o        (arb_any)
    );

    assign oob = (32'(x0_q) >= 32'(CANVAS_DIM)) || (32'(y0_q) >= 32'(CANVAS_DIM)) ||
                 (32'(x1_q) >= 32'(CANVAS_DIM)) || (32'(y1_q) >= 32'(CANVAS_DIM));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        fail_d  = fail_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    x0_d    = req_x0[arb_idx];
                    y0_d    = req_y0[arb_idx];
                    x1_d    = req_x1[arb_idx];
                    y1_d    = req_y1[arb_idx];
                    grant_d = arb_idx;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (oob) begin
                    err_d   = ERR_BOUNDS;
                    fail_d  = 1'b1;
                    state_d = ST_REPORT;
                end else begin
                    fail_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done arriving on the timeout cycle still counts as success.
                if (eng_done) begin
                    fail_d  = 1'b0;
                    state_d = ST_REPORT;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = ERR_TIMEOUT;
                    fail_d  = 1'b1;
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                last_d  = grant_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            fail_q  <= 1'b0;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
        end
    end

    assign ack_vec   = NUM_REQ'(1) << grant_q;
    assign req_ready = (state_q == ST_IDLE) ? arb_grant : '0;
    assign done_ack  = (state_q == ST_REPORT && !fail_q) ? ack_vec : '0;
    assign err_ack   = (state_q == ST_REPORT &&  fail_q) ? ack_vec : '0;
    assign eng_start = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);
    assign err_code  = err_q;
    assign grant_id  = grant_q;
    assign eng_x0    = x0_q;
    assign eng_y0    = y0_q;
    assign eng_x1    = x1_q;
    assign eng_y1    = y1_q;

endmodule
`default_nettype wire
